// File: rtl/wb_pkg.sv
// Shared encodings and entry layout for the writeback stage.
// Datapath is fixed at 32 bits with 5-bit register addresses.
package wb_pkg;
    localparam int WB_DW = 32;
    localparam int WB_AW = 5;

    localparam logic [1:0] WB_SEL_ALU  = 2'd0;
    localparam logic [1:0] WB_SEL_LOAD = 2'd1;
    localparam logic [1:0] WB_SEL_LINK = 2'd2;

    localparam logic [2:0] LD_LB  = 3'd0;
    localparam logic [2:0] LD_LBU = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LW  = 3'd4;

    localparam logic [WB_DW-1:0] LINK_OFFSET = 32'd8;

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_t;

    typedef struct packed {
        logic             reg_write;
        logic [WB_AW-1:0] dst;
        logic [WB_DW-1:0] data;
        logic             misalign;
    } entry_t;
endpackage

// File: rtl/wb_load_align.sv
// Little-endian load lane select with sign/zero extension and alignment check.
// Purely combinational; no backpressure.
module wb_load_align
    import wb_pkg::*;
(
    input  logic [2:0]  ld_type,
    input  logic [1:0]  addr,
    input  logic [31:0] raw,
    output logic [31:0] data,
    output logic        misalign
);
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v   = raw[{addr, 3'b000} +: 8];
        half_v   = addr[1] ? raw[31:16] : raw[15:0];
        data     = raw;
        misalign = 1'b0;
        case (ld_type)
            LD_LB:   data = {{24{byte_v[7]}}, byte_v};
            LD_LBU:  data = {24'd0, byte_v};
            LD_LH: begin
                data     = {{16{half_v[15]}}, half_v};
                misalign = addr[0];
            end
            LD_LHU: begin
                data     = {16'd0, half_v};
                misalign = addr[0];
            end
            // LW and every unassigned encoding load the whole word
            default: begin
                data     = raw;
                misalign = (addr != 2'b00);
            end
        endcase
    end
endmodule

// File: rtl/wb_stage.sv
// Writeback stage: 2-entry skid buffer feeding the register file write port; define WB_FWD_EN for the RF bypass.
// Latency 1 cycle from accept to write; mem_ready is a flop that drops while both entries are full.
module wb_stage
    import wb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic             elk,
    input  logic             nrst,
    input  logic             mem_valid,
    output logic             mem_ready,
    input  logic             mem_reg_write,
    input  logic [AW-1:0]    mem_dst,
    input  logic [1:0]       mem_wb_sel,
    input  logic [2:0]       mem_ld_type,
    input  logic [DW-1:0]    mem_alu_res,
    input  logic [DW-1:0]    mem_load_data,
    input  logic [DW-1:0]    mem_pc,
    input  logic             wb_hold,
    output logic             wr_en,
    output logic [AW-1:0]    wr_addr,
    output logic [DW-1:0]    wr_data,
    output logic             misalign_err,
`ifdef WB_FWD_EN
    input  logic [AW-1:0]    fwd_addrA,
    input  logic [AW-1:0]    fwd_addrB,
    input  logic [DW-1:0]    rf_dataA,
    input  logic [DW-1:0]    rf_dataB,
    output logic [DW-1:0]    fwd_dataA,
    output logic [DW-1:0]    fwd_dataB,
`endif
    output logic [CNT_W-1:0] retire_cnt
);
    occ_t        state, state_nxt;
    entry_t      head, skid, new_entry;
    logic        head_valid, accept, retire;
    logic        load_head, load_skid, head_from_skid;
    logic [31:0] ld_data;
    logic        ld_mis;

    wb_load_align u_align (
        .ld_type  (mem_ld_type),
        .addr     (mem_alu_res[1:0]),
        .raw      (mem_load_data),
        .data     (ld_data),
        .misalign (ld_mis)
    );

    always_comb begin
        new_entry.reg_write = mem_reg_write;
        new_entry.dst       = mem_dst;
        new_entry.data      = mem_alu_res;
        new_entry.misalign  = 1'b0;
        case (mem_wb_sel)
            WB_SEL_LOAD: begin
                new_entry.data     = ld_data;
                new_entry.misalign = ld_mis;
            end
            WB_SEL_LINK: new_entry.data = mem_pc + LINK_OFFSET;
            default:     new_entry.data = mem_alu_res;
        endcase
    end

    assign head_valid = (state != OCC_EMPTY);
    assign accept     = mem_valid & mem_ready;
    assign retire     = head_valid & ~wb_hold;

    always_comb begin
        state_nxt      = state;
        load_head      = 1'b0;
        load_skid      = 1'b0;
        head_from_skid = 1'b0;
        case (state)
            OCC_EMPTY: begin
                if (accept) begin
                    state_nxt = OCC_ONE;
                    load_head = 1'b1;
                end
            end
            OCC_ONE: begin
                if (accept && retire) begin
                    load_head = 1'b1;
                end else if (accept) begin
                    state_nxt = OCC_TWO;
                    load_skid = 1'b1;
                end else if (retire) begin
                    state_nxt = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                // mem_ready is low here, so the only event is the head retiring
                if (retire) begin
                    state_nxt      = OCC_ONE;
                    head_from_skid = 1'b1;
                end
            end
            default: state_nxt = OCC_EMPTY;
        endcase
    end

    always_ff @(posedge elk) begin
        if (!nrst) begin
            state     <= OCC_EMPTY;
            mem_ready <= 1'b1;
        end else begin
            state     <= state_nxt;
            mem_ready <= (state_nxt != OCC_TWO);
        end
    end

    always_ff @(posedge elk) begin
        if (!nrst) begin
            head <= '0;
            skid <= '0;
        end else begin
            if (load_head) begin
                head <= new_entry;
            end else if (head_from_skid) begin
                head <= skid;
            end
            if (load_skid) begin
                skid <= new_entry;
            end
        end
    end

    always_ff @(posedge elk) begin
        if (!nrst) begin
            misalign_err <= 1'b0;
            retire_cnt   <= '0;
        end else if (retire) begin
            misalign_err <= misalign_err | head.misalign;
            retire_cnt   <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign wr_en   = head_valid & head.reg_write & (head.dst != '0) & ~head.misalign & ~wb_hold;
    assign wr_addr = head.dst;
    assign wr_data = head.data;

`ifdef WB_FWD_EN
    assign fwd_dataA = (wr_en && (wr_addr == fwd_addrA)) ? wr_data : rf_dataA;
    assign fwd_dataB = (wr_en && (wr_addr == fwd_addrB)) ? wr_data : rf_dataB;
`endif
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed table, hand-written corner sequences, and a random run against a queue model.
module tb_wb_stage;
    localparam int CW = 8;

    logic          elk = 1'b0;
    logic          nrst;
    logic          mem_valid, mem_ready, mem_reg_write;
    logic [4:0]    mem_dst;
    logic [1:0]    mem_wb_sel;
    logic [2:0]    mem_ld_type;
    logic [31:0]   mem_alu_res, mem_load_data, mem_pc;
    logic          wb_hold;
    logic          wr_en;
    logic [4:0]    wr_addr;
    logic [31:0]   wr_data;
    logic          misalign_err;
    logic [CW-1:0] retire_cnt;
`ifdef WB_FWD_EN
    logic [4:0]    fwd_addrA = '0, fwd_addrB = '0;
    logic [31:0]   rf_dataA = '0, rf_dataB = '0;
    logic [31:0]   fwd_dataA, fwd_dataB;
`endif

    always #5 elk = ~elk;

    wb_stage #(.DW(32), .AW(5), .CNT_W(CW)) dut (
        .elk           (elk),
        .nrst          (nrst),
        .mem_valid     (mem_valid),
        .mem_ready     (mem_ready),
        .mem_reg_write (mem_reg_write),
        .mem_dst       (mem_dst),
        .mem_wb_sel    (mem_wb_sel),
        .mem_ld_type   (mem_ld_type),
        .mem_alu_res   (mem_alu_res),
        .mem_load_data (mem_load_data),
        .mem_pc        (mem_pc),
        .wb_hold       (wb_hold),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .misalign_err  (misalign_err),
`ifdef WB_FWD_EN
        .fwd_addrA     (fwd_addrA),
        .fwd_addrB     (fwd_addrB),
        .rf_dataA      (rf_dataA),
        .rf_dataB      (rf_dataB),
        .fwd_dataA     (fwd_dataA),
        .fwd_dataB     (fwd_dataB),
`endif
        .retire_cnt    (retire_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        mem_valid     = 1'b0;
        mem_reg_write = 1'b0;
        mem_dst       = '0;
        mem_wb_sel    = '0;
        mem_ld_type   = '0;
        mem_alu_res   = '0;
        mem_load_data = '0;
        mem_pc        = '0;
        wb_hold       = 1'b0;
    endtask

    task automatic drive(input logic rw, input logic [4:0] dst, input logic [1:0] sel,
                         input logic [2:0] ldt, input logic [31:0] alu, input logic [31:0] raw,
                         input logic [31:0] pc);
        mem_valid     = 1'b1;
        mem_reg_write = rw;
        mem_dst       = dst;
        mem_wb_sel    = sel;
        mem_ld_type   = ldt;
        mem_alu_res   = alu;
        mem_load_data = raw;
        mem_pc        = pc;
    endtask

    // Returns at a falling edge with reset just released and nothing clocked since.
    task automatic do_reset();
        nrst = 1'b0;
        idle_inputs();
        repeat (2) @(posedge elk);
        @(negedge elk);
        nrst = 1'b1;
    endtask

    // Reference: value a retiring instruction should write, from the ISA-level rules.
    function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [2:0] ldt,
                                             input logic [31:0] alu, input logic [31:0] raw,
                                             input logic [31:0] pc);
        int unsigned lane = alu % 4;
        logic [31:0] b = (raw >> (8 * lane)) & 32'hFF;
        logic [31:0] h = (raw >> (16 * (lane / 2))) & 32'hFFFF;
        if (sel == 2'd2) return pc + 32'd8;
        if (sel != 2'd1) return alu;
        case (ldt)
            3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
            3'd1:    return b;
            3'd2:    return (h >= 32'd32768) ? h - 32'd65536 : h;
            3'd3:    return h;
            default: return raw;
        endcase
    endfunction

    function automatic bit ref_mis(input logic [1:0] sel, input logic [2:0] ldt, input logic [31:0] alu);
        if (sel != 2'd1) return 1'b0;
        if (ldt == 3'd2 || ldt == 3'd3) return (alu % 2) != 0;
        if (ldt >= 3'd4) return (alu % 4) != 0;
        return 1'b0;
    endfunction

    typedef struct {
        logic [1:0]  sel;
        logic [2:0]  ldt;
        logic [31:0] alu;
        logic [31:0] raw;
        logic [31:0] pc;
        logic [31:0] exp;
    } vec_t;

    typedef struct {
        logic        rw;
        logic [4:0]  dst;
        logic [31:0] data;
        bit          mis;
    } exp_t;

    vec_t          vt[10];
    exp_t          q[$];
    bit            m_ready, m_err, acc, ret;
    logic [CW-1:0] m_cnt;
    int            exp_cnt;

    initial begin
        vt[0] = '{2'd1, 3'd0, 32'h0000_1003, 32'h80FF_FFFF, 32'h0, 32'hFFFF_FF80};
        vt[1] = '{2'd1, 3'd1, 32'h0000_1003, 32'h80FF_FFFF, 32'h0, 32'h0000_0080};
        vt[2] = '{2'd1, 3'd2, 32'h0000_2002, 32'h8001_0000, 32'h0, 32'hFFFF_8001};
        vt[3] = '{2'd1, 3'd3, 32'h0000_2000, 32'h1234_F00D, 32'h0, 32'h0000_F00D};
        vt[4] = '{2'd1, 3'd0, 32'h0000_0000, 32'h0000_007F, 32'h0, 32'h0000_007F};
        vt[5] = '{2'd1, 3'd1, 32'h0000_0001, 32'h0000_AB00, 32'h0, 32'h0000_00AB};
        vt[6] = '{2'd1, 3'd4, 32'h0000_0004, 32'hCAFE_BABE, 32'h0, 32'hCAFE_BABE};
        vt[7] = '{2'd1, 3'd7, 32'h0000_0008, 32'h1122_3344, 32'h0, 32'h1122_3344};
        vt[8] = '{2'd2, 3'd0, 32'h0000_0000, 32'h0,         32'hFFFF_FFFC, 32'h0000_0004};
        vt[9] = '{2'd3, 3'd0, 32'hA5A5_0F0F, 32'h0,         32'h0, 32'hA5A5_0F0F};

        // Reset state
        do_reset();
        chk("rst_ready", 32'(mem_ready), 32'd1);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", wr_data, 32'd0);
        chk("rst_mis_err", 32'(misalign_err), 32'd0);
        chk("rst_cnt", 32'(retire_cnt), 32'd0);
        exp_cnt = 0;

        // First ALU op: visible the cycle after acceptance
        drive(1'b1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0);
        @(negedge elk);
        chk("alu_wr_en", 32'(wr_en), 32'd1);
        chk("alu_wr_addr", 32'(wr_addr), 32'd5);
        chk("alu_wr_data", wr_data, 32'h1234_5678);
        mem_valid = 1'b0;
        @(negedge elk);
        exp_cnt++;
        chk("alu_cnt", 32'(retire_cnt), 32'(exp_cnt));
        chk("alu_drained", 32'(wr_en), 32'd0);

        // Table of load/link/alu vectors
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(i + 1), vt[i].sel, vt[i].ldt, vt[i].alu, vt[i].raw, vt[i].pc);
            @(negedge elk);
            chk($sformatf("vec%0d_wr_en", i), 32'(wr_en), 32'd1);
            chk($sformatf("vec%0d_wr_addr", i), 32'(wr_addr), 32'(i + 1));
            chk($sformatf("vec%0d_wr_data", i), wr_data, vt[i].exp);
            mem_valid = 1'b0;
            @(negedge elk);
            exp_cnt++;
        end
        chk("vec_cnt", 32'(retire_cnt), 32'(exp_cnt));
        chk("vec_mis_err", 32'(misalign_err), 32'd0);

`ifdef WB_FWD_EN
        drive(1'b1, 5'd7, 2'd0, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0);
        fwd_addrA = 5'd7;
        rf_dataA  = 32'h0;
        fwd_addrB = 5'd0;
        rf_dataB  = 32'h55AA_55AA;
        @(negedge elk);
        chk("fwd_a_hit", fwd_dataA, 32'hDEAD_BEEF);
        chk("fwd_b_r0", fwd_dataB, 32'h55AA_55AA);
        mem_valid = 1'b0;
        @(negedge elk);
        exp_cnt++;
        chk("fwd_a_idle", fwd_dataA, 32'h0);
`endif

        // Misaligned LW: retires, no write, sticky error
        drive(1'b1, 5'd3, 2'd1, 3'd4, 32'h0000_0102, 32'h1111_2222, 32'h0);
        @(negedge elk);
        chk("mis_wr_en", 32'(wr_en), 32'd0);
        mem_valid = 1'b0;
        @(negedge elk);
        exp_cnt++;
        chk("mis_err_set", 32'(misalign_err), 32'd1);
        chk("mis_cnt", 32'(retire_cnt), 32'(exp_cnt));
        drive(1'b1, 5'd4, 2'd0, 3'd0, 32'h0000_0044, 32'h0, 32'h0);
        @(negedge elk);
        chk("post_mis_wr_en", 32'(wr_en), 32'd1);
        mem_valid = 1'b0;
        @(negedge elk);
        exp_cnt++;
        chk("mis_err_sticky", 32'(misalign_err), 32'd1);

        // dst=0 never writes but still retires
        drive(1'b1, 5'd0, 2'd0, 3'd0, 32'hFFFF_FFFF, 32'h0, 32'h0);
        @(negedge elk);
        chk("r0_wr_en", 32'(wr_en), 32'd0);
        mem_valid = 1'b0;
        @(negedge elk);
        exp_cnt++;
        chk("r0_cnt", 32'(retire_cnt), 32'(exp_cnt));

        // Hold with three back-to-back valids: two accepted, third refused
        wb_hold = 1'b1;
        drive(1'b1, 5'd10, 2'd0, 3'd0, 32'hAAAA_0001, 32'h0, 32'h0);
        @(negedge elk);
        chk("hold_wr_en", 32'(wr_en), 32'd0);
        chk("hold_addr_a", 32'(wr_addr), 32'd10);
        drive(1'b1, 5'd11, 2'd0, 3'd0, 32'hBBBB_0002, 32'h0, 32'h0);
        @(negedge elk);
        chk("hold_full_ready", 32'(mem_ready), 32'd0);
        drive(1'b1, 5'd12, 2'd0, 3'd0, 32'hCCCC_0003, 32'h0, 32'h0);
        @(negedge elk);
        chk("hold_still_full", 32'(mem_ready), 32'd0);
        chk("hold_stable_data", wr_data, 32'hAAAA_0001);
        mem_valid = 1'b0;
        wb_hold   = 1'b0;
        #1;
        chk("rel_a_en", 32'(wr_en), 32'd1);
        chk("rel_a_addr", 32'(wr_addr), 32'd10);
        chk("rel_a_data", wr_data, 32'hAAAA_0001);
        @(negedge elk);
        chk("rel_b_en", 32'(wr_en), 32'd1);
        chk("rel_b_addr", 32'(wr_addr), 32'd11);
        chk("rel_b_data", wr_data, 32'hBBBB_0002);
        chk("rel_ready", 32'(mem_ready), 32'd1);
        @(negedge elk);
        exp_cnt += 2;
        chk("rel_no_c", 32'(wr_en), 32'd0);
        chk("rel_cnt", 32'(retire_cnt), 32'(exp_cnt));

        // Reset while two entries are buffered discards them
        wb_hold = 1'b1;
        drive(1'b1, 5'd20, 2'd0, 3'd0, 32'h2020_2020, 32'h0, 32'h0);
        @(negedge elk);
        drive(1'b1, 5'd21, 2'd0, 3'd0, 32'h2121_2121, 32'h0, 32'h0);
        @(negedge elk);
        do_reset();
        chk("mid_rst_ready", 32'(mem_ready), 32'd1);
        chk("mid_rst_wr_en", 32'(wr_en), 32'd0);
        chk("mid_rst_err", 32'(misalign_err), 32'd0);
        chk("mid_rst_cnt", 32'(retire_cnt), 32'd0);
        @(negedge elk);
        chk("mid_rst_quiet", 32'(wr_en), 32'd0);

        // Counter wrap: 256 back-to-back retirements on an 8-bit counter
        drive(1'b0, 5'd1, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0);
        repeat (256) @(posedge elk);
        @(negedge elk);
        chk("wrap_max", 32'(retire_cnt), 32'd255);
        mem_valid = 1'b0;
        @(negedge elk);
        chk("wrap_zero", 32'(retire_cnt), 32'd0);

        // Random traffic against a queue model
        do_reset();
        q.delete();
        m_ready = 1'b1;
        m_err   = 1'b0;
        m_cnt   = '0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            mem_valid     = ($urandom_range(0, 9) < 6);
            wb_hold       = ($urandom_range(0, 9) < 3);
            mem_reg_write = ($urandom_range(0, 7) != 0);
            mem_dst       = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            mem_wb_sel    = 2'($urandom_range(0, 3));
            mem_ld_type   = 3'($urandom_range(0, 7));
            mem_alu_res   = $urandom();
            mem_load_data = $urandom();
            mem_pc        = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFC : $urandom();
            #1;
            chk("rnd_ready", 32'(mem_ready), 32'(m_ready));
            chk("rnd_wr_en", 32'(wr_en),
                32'(q.size() > 0 && q[0].rw && q[0].dst != 0 && !q[0].mis && !wb_hold));
            if (q.size() > 0) begin
                chk("rnd_wr_addr", 32'(wr_addr), 32'(q[0].dst));
                chk("rnd_wr_data", wr_data, q[0].data);
            end
            chk("rnd_mis_err", 32'(misalign_err), 32'(m_err));
            chk("rnd_cnt", 32'(retire_cnt), 32'(m_cnt));
            @(posedge elk);
            acc = mem_valid && m_ready;
            ret = (q.size() > 0) && !wb_hold;
            if (ret) begin
                if (q[0].mis) m_err = 1'b1;
                void'(q.pop_front());
                m_cnt = m_cnt + 1'b1;
            end
            if (acc) begin
                q.push_back('{mem_reg_write, mem_dst,
                              ref_data(mem_wb_sel, mem_ld_type, mem_alu_res, mem_load_data, mem_pc),
                              ref_mis(mem_wb_sel, mem_ld_type, mem_alu_res)});
            end
            m_ready = (q.size() < 2);
            @(negedge elk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
